ysyx_25040111_mem_arbiter: RTL and testbench

Shares the single downstream memory port between two masters: the icache refill path (read-only, burst) and the LSU (single-beat read/write). Only one transaction is in flight at a time. Arbitration on ties is round-robin. A response timeout returns an error to the granted master. The block sits between the icache/LSU and the memory bus bridge.

---
 rtl/ysyx_25040111_pkg.sv | 15 +
 rtl/ysyx_25040111_arb_timer.sv | 28 ++
 rtl/ysyx_25040111_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_25040111_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_pkg.sv
// Shared types and constants for the memory arbiter slice.
package ysyx_25040111_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } arb_state_t;

    localparam logic GNT_CAH = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    localparam int RSP_W = 32;

endpackage

// File: rtl/ysyx_25040111_arb_timer.sv
// Response watchdog: counts idle RSP cycles, flags expiry at TIMEOUT-1.
module ysyx_25040111_arb_timer #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [TW-1:0] count,
    output logic          expire
);

    // Clear wins over increment so a beat always restarts the window.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TW'(1);
        end
    end

    // Expiry is a plain compare so the synthetic beat lands in the same cycle.
    always_comb begin
        expire = (count == TW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Two-master (icache refill / LSU) arbiter onto one downstream memory port.
// One transaction in flight; round-robin on ties; watchdog abort in RSP.
//
// state  | meaning
// IDLE   | no transaction; pick a master from the valids
// REQ    | drive the granted request downstream until m_req_ready
// RSP    | forward response beats to the granted master, watch for timeout
module ysyx_25040111_mem_arbiter
    import ysyx_25040111_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             c_valid,
    output logic             c_ready,
    input  logic [31:0]      c_addr,
    input  logic [7:0]       c_len,
    output logic             c_rvalid,
    output logic [RSP_W-1:0] c_rdata,
    output logic             c_rlast,
    output logic             c_err,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic             l_write,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    input  logic [3:0]       l_wstrb,
    output logic             l_rvalid,
    output logic [RSP_W-1:0] l_rdata,
    output logic             l_err,
    output logic             m_req_valid,
    input  logic             m_req_ready,
    output logic [31:0]      m_req_addr,
    output logic             m_req_write,
    output logic [31:0]      m_req_wdata,
    output logic [3:0]       m_req_wstrb,
    output logic [7:0]       m_req_len,
    input  logic             m_rsp_valid,
    input  logic [RSP_W-1:0] m_rsp_data,
    input  logic             m_rsp_last,
    input  logic             m_rsp_err
);

    arb_state_t    state;
    logic          g;
    logic          last_grant;
    logic [7:0]    beat;
    logic [7:0]    g_len;
    logic          g_write;

    logic [TW-1:0] tmr_count;
    logic          tmr_clear;
    logic          tmr_inc;
    logic          tmr_expire;

    logic          nxt_g;
    logic          accept;
    logic          rsp_beat;
    logic          timeout_beat;
    logic          at_len;
    logic          beat_done;
    logic          beat_err;

    // Decode of grant choice and response-beat conditions.
    always_comb begin
        nxt_g = GNT_CAH;
        if (c_valid && l_valid) begin
            nxt_g = ~last_grant;
        end else if (l_valid) begin
            nxt_g = GNT_LSU;
        end
        accept       = (state == S_REQ) && m_req_ready;
        rsp_beat     = (state == S_RSP) && m_rsp_valid;
        timeout_beat = (state == S_RSP) && !m_rsp_valid && tmr_expire;
        at_len       = (beat == g_len);
        // A beat closes the transaction on last or on reaching the granted
        // length; any disagreement between the two is reported as an error.
        beat_done    = m_rsp_last || at_len;
        beat_err     = m_rsp_err || (m_rsp_last != at_len);
        tmr_clear    = accept || rsp_beat;
        tmr_inc      = (state == S_RSP) && !m_rsp_valid;
    end

    ysyx_25040111_arb_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // Transaction sequencer; length and direction are captured at accept
    // because masters may change their fields after the ready pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            g          <= GNT_CAH;
            last_grant <= GNT_LSU;
            beat       <= 8'd0;
            g_len      <= 8'd0;
            g_write    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c_valid || l_valid) begin
                        g          <= nxt_g;
                        last_grant <= nxt_g;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_req_ready) begin
                        beat    <= 8'd0;
                        g_len   <= (g == GNT_LSU) ? 8'd0 : c_len;
                        g_write <= (g == GNT_LSU) && l_write;
                        state   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (m_rsp_valid) begin
                        beat <= beat + 8'd1;
                        if (beat_done) begin
                            state <= S_IDLE;
                        end
                    end else if (tmr_expire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request mux and response steering; the non-granted side stays quiet.
    always_comb begin
        logic [RSP_W-1:0] rsp_data;
        logic             rsp_err;
        logic             rsp_last;

        c_ready     = 1'b0;
        l_ready     = 1'b0;
        c_rvalid    = 1'b0;
        c_rdata     = '0;
        c_rlast     = 1'b0;
        c_err       = 1'b0;
        l_rvalid    = 1'b0;
        l_rdata     = '0;
        l_err       = 1'b0;
        m_req_valid = 1'b0;
        m_req_addr  = 32'd0;
        m_req_write = 1'b0;
        m_req_wdata = 32'd0;
        m_req_wstrb = 4'd0;
        m_req_len   = 8'd0;
        rsp_data    = timeout_beat ? '0 : m_rsp_data;
        rsp_err     = timeout_beat || beat_err;
        rsp_last    = timeout_beat || beat_done;

        if (state == S_REQ) begin
            m_req_valid = 1'b1;
            if (g == GNT_LSU) begin
                m_req_addr  = l_addr;
                m_req_write = l_write;
                m_req_wdata = l_wdata;
                m_req_wstrb = l_wstrb;
                l_ready     = m_req_ready;
            end else begin
                m_req_addr  = c_addr;
                m_req_len   = c_len;
                c_ready     = m_req_ready;
            end
        end

        if (rsp_beat || timeout_beat) begin
            if (g == GNT_LSU) begin
                l_rvalid = 1'b1;
                l_rdata  = g_write ? '0 : rsp_data;
                l_err    = rsp_err;
            end else begin
                c_rvalid = 1'b1;
                c_rdata  = rsp_data;
                c_rlast  = rsp_last;
                c_err    = rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Directed bench for the icache/LSU memory arbiter (TIMEOUT = 8).
module tb_ysyx_25040111_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        c_valid;
    logic        c_ready;
    logic [31:0] c_addr;
    logic [7:0]  c_len;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        c_rlast;
    logic        c_err;
    logic        l_valid;
    logic        l_ready;
    logic        l_write;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_wstrb;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_req_addr;
    logic        m_req_write;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic [7:0]  m_req_len;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic        m_rsp_last;
    logic        m_rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    logic any_out;
    assign any_out = |{c_ready, c_rvalid, c_rdata, c_rlast, c_err,
                       l_ready, l_rvalid, l_rdata, l_err,
                       m_req_valid, m_req_addr, m_req_write, m_req_wdata,
                       m_req_wstrb, m_req_len};

    ysyx_25040111_mem_arbiter #(
        .TIMEOUT (8),
        .TW      (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_addr      (c_addr),
        .c_len       (c_len),
        .c_rvalid    (c_rvalid),
        .c_rdata     (c_rdata),
        .c_rlast     (c_rlast),
        .c_err       (c_err),
        .l_valid     (l_valid),
        .l_ready     (l_ready),
        .l_write     (l_write),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_wstrb     (l_wstrb),
        .l_rvalid    (l_rvalid),
        .l_rdata     (l_rdata),
        .l_err       (l_err),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_addr  (m_req_addr),
        .m_req_write (m_req_write),
        .m_req_wdata (m_req_wdata),
        .m_req_wstrb (m_req_wstrb),
        .m_req_len   (m_req_len),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .m_rsp_last  (m_rsp_last),
        .m_rsp_err   (m_rsp_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // From IDLE (at posedge+1, request already driven): one IDLE cycle, one
    // REQ cycle with slave ready; leaves the bench at posedge+1 in RSP.
    task automatic idle_to_accept(input bit is_lsu, input logic [31:0] exp_addr,
                                  input logic [7:0] exp_len, input bit drop);
        m_req_ready = 1'b1;
        m_rsp_valid = 1'b0;
        m_rsp_last  = 1'b0;
        @(negedge clock);
        chk("idle_no_req", m_req_valid, 0);
        next();
        @(negedge clock);
        chk("req_valid", m_req_valid, 1);
        chk("req_addr", m_req_addr, exp_addr);
        chk("req_len", m_req_len, exp_len);
        chk("req_write", m_req_write, is_lsu ? l_write : 1'b0);
        chk("req_wdata", m_req_wdata, is_lsu ? l_wdata : 32'd0);
        chk("c_ready", c_ready, !is_lsu);
        chk("l_ready", l_ready, is_lsu);
        next();
        if (drop) begin
            if (is_lsu) l_valid = 1'b0;
            else        c_valid = 1'b0;
        end
        m_req_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        c_valid = 0; c_addr = 0; c_len = 0;
        l_valid = 0; l_write = 0; l_addr = 0; l_wdata = 0; l_wstrb = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rsp_data = 0; m_rsp_last = 0; m_rsp_err = 0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_outputs_zero", any_out, 0);
        next();
        reset = 1'b0;

        // LSU read, slave ready after two cycles.
        l_valid = 1; l_write = 0; l_addr = 32'h8000_0010;
        @(negedge clock);
        chk("t1_idle", m_req_valid, 0);
        next();
        @(negedge clock);
        chk("t1_req_valid", m_req_valid, 1);
        chk("t1_req_addr", m_req_addr, 32'h8000_0010);
        chk("t1_no_ready0", l_ready, 0);
        next();
        @(negedge clock);
        chk("t1_no_ready1", l_ready, 0);
        next();
        m_req_ready = 1;
        @(negedge clock);
        chk("t1_l_ready", l_ready, 1);
        chk("t1_req_len", m_req_len, 0);
        next();
        l_valid = 0; m_req_ready = 0;
        m_rsp_valid = 1; m_rsp_data = 32'hDEAD_BEEF; m_rsp_last = 1;
        @(negedge clock);
        chk("t1_l_rvalid", l_rvalid, 1);
        chk("t1_l_rdata", l_rdata, 32'hDEAD_BEEF);
        chk("t1_l_err", l_err, 0);
        chk("t1_c_rvalid", c_rvalid, 0);
        chk("t1_ready_once", l_ready, 0);
        next();
        m_rsp_valid = 0; m_rsp_last = 0;
        @(negedge clock);
        chk("t1_back_idle", m_req_valid, 0);
        chk("t1_rvalid_low", l_rvalid, 0);
        next();

        // Round-robin with both masters held valid from the first cycle after reset.
        reset = 1;
        next();
        reset = 0;
        c_valid = 1; c_addr = 32'h0000_1000; c_len = 0;
        l_valid = 1; l_write = 1; l_addr = 32'h0000_2000; l_wdata = 32'hCAFE_0001; l_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bit is_l;
            is_l = (i % 2) == 1;
            idle_to_accept(is_l, is_l ? 32'h0000_2000 : 32'h0000_1000, 8'd0, 1'b0);
            m_rsp_valid = 1; m_rsp_data = 32'hA5A5_0000 + i; m_rsp_last = 1;
            @(negedge clock);
            if (is_l) begin
                chk("t2_l_rvalid", l_rvalid, 1);
                chk("t2_l_wr_rdata0", l_rdata, 0);
                chk("t2_c_quiet", c_rvalid, 0);
            end else begin
                chk("t2_c_rvalid", c_rvalid, 1);
                chk("t2_c_rdata", c_rdata, 32'hA5A5_0000 + i);
                chk("t2_c_rlast", c_rlast, 1);
                chk("t2_l_quiet", l_rvalid, 0);
            end
            next();
        end
        c_valid = 0; l_valid = 0; l_write = 0;
        m_rsp_valid = 0; m_rsp_last = 0;
        @(negedge clock);
        chk("t2_idle", m_req_valid, 0);
        next();

        // Cache burst of 4 beats, last on beat 4.
        c_valid = 1; c_addr = 32'h0000_3000; c_len = 3;
        idle_to_accept(1'b0, 32'h0000_3000, 8'd3, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            m_rsp_valid = 1; m_rsp_data = j; m_rsp_last = (j == 4);
            @(negedge clock);
            chk("t3_c_rvalid", c_rvalid, 1);
            chk("t3_c_rdata", c_rdata, j);
            chk("t3_c_rlast", c_rlast, (j == 4));
            chk("t3_c_err", c_err, 0);
            next();
        end
        m_rsp_valid = 0; m_rsp_last = 0;
        @(negedge clock);
        chk("t3_idle_rvalid", c_rvalid, 0);
        next();

        // Early last on beat 2 of 4.
        c_valid = 1; c_addr = 32'h0000_4000; c_len = 3;
        idle_to_accept(1'b0, 32'h0000_4000, 8'd3, 1'b1);
        m_rsp_valid = 1; m_rsp_data = 32'h11; m_rsp_last = 0;
        @(negedge clock);
        chk("t4a_b1_err", c_err, 0);
        chk("t4a_b1_last", c_rlast, 0);
        next();
        m_rsp_data = 32'h22; m_rsp_last = 1;
        @(negedge clock);
        chk("t4a_b2_rvalid", c_rvalid, 1);
        chk("t4a_b2_err", c_err, 1);
        next();
        m_rsp_valid = 0; m_rsp_last = 0;
        @(negedge clock);
        chk("t4a_idle", m_req_valid, 0);
        chk("t4a_idle_rvalid", c_rvalid, 0);
        next();

        // Five beats without last: error and forced last on beat 4.
        c_valid = 1; c_addr = 32'h0000_5000; c_len = 3;
        idle_to_accept(1'b0, 32'h0000_5000, 8'd3, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            m_rsp_valid = 1; m_rsp_data = 32'h50 + j; m_rsp_last = 0;
            @(negedge clock);
            if (j < 4) begin
                chk("t4b_rvalid", c_rvalid, 1);
                chk("t4b_err", c_err, 0);
                chk("t4b_rlast", c_rlast, 0);
            end else if (j == 4) begin
                chk("t4b_b4_rvalid", c_rvalid, 1);
                chk("t4b_b4_err", c_err, 1);
                chk("t4b_b4_forced_last", c_rlast, 1);
            end else begin
                chk("t4b_b5_dropped", c_rvalid, 0);
            end
            next();
        end
        m_rsp_valid = 0;

        // LSU write with a silent slave: timeout on the 8th RSP cycle.
        l_valid = 1; l_write = 1; l_addr = 32'h0000_6000; l_wdata = 32'h1111_2222; l_wstrb = 4'h3;
        idle_to_accept(1'b1, 32'h0000_6000, 8'd0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            chk("t5_silent", l_rvalid, 0);
            next();
        end
        @(negedge clock);
        chk("t5_to_rvalid", l_rvalid, 1);
        chk("t5_to_err", l_err, 1);
        chk("t5_to_rdata", l_rdata, 0);
        chk("t5_c_quiet", c_rvalid, 0);
        next();
        l_write = 0;
        m_rsp_valid = 1; m_rsp_data = 32'hFFFF_FFFF; m_rsp_last = 1;
        @(negedge clock);
        chk("t5_late_ignored", l_rvalid, 0);
        next();
        m_rsp_valid = 0; m_rsp_last = 0;

        // Reset after beat 2 of a 4-beat burst, then a normal LSU read.
        c_valid = 1; c_addr = 32'h0000_7000; c_len = 3;
        idle_to_accept(1'b0, 32'h0000_7000, 8'd3, 1'b1);
        for (int j = 1; j <= 2; j++) begin
            m_rsp_valid = 1; m_rsp_data = 32'h70 + j; m_rsp_last = 0;
            @(negedge clock);
            chk("t6_beat", c_rvalid, 1);
            next();
        end
        m_rsp_valid = 0;
        reset = 1;
        next();
        reset = 0;
        @(negedge clock);
        chk("t6_reset_zero", any_out, 0);
        next();
        l_valid = 1; l_write = 0; l_addr = 32'h8000_0020;
        idle_to_accept(1'b1, 32'h8000_0020, 8'd0, 1'b1);
        m_rsp_valid = 1; m_rsp_data = 32'h1234_5678; m_rsp_last = 1;
        @(negedge clock);
        chk("t6_l_rvalid", l_rvalid, 1);
        chk("t6_l_rdata", l_rdata, 32'h1234_5678);
        chk("t6_l_err", l_err, 0);
        next();
        m_rsp_valid = 0; m_rsp_last = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
